// File: rtl/sa_cache_2way.sv
// sa_cache_2way: two-way set-associative, write-through, no-write-allocate
// data cache with per-set LRU replacement.
//
// Misses and stores go through a small FSM (IDLE / REFILL / WRITE).
// The FSM talks to memory with a request/acknowledge handshake and holds
// the CPU with stall until the access is complete.
//
// Optional build macro CACHE_STATS_EN adds two free-running 32-bit counters,
// hit_count and miss_count, for load hits and load misses seen in IDLE.
module sa_cache_2way #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  hit,
    output logic                  miss,
    output logic                  stall,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_valid
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int TAG_W    = ADDR_WIDTH - SET_BITS - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Storage: two ways of {valid, tag, data} per set, plus one LRU bit per set
    // that names the way to replace next.
    logic [NUM_SETS-1:0] valid0_r;
    logic [NUM_SETS-1:0] valid1_r;
    logic [NUM_SETS-1:0] lru_r;
    logic [TAG_W-1:0]      tag0_r  [NUM_SETS];
    logic [TAG_W-1:0]      tag1_r  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data0_r [NUM_SETS];
    logic [DATA_WIDTH-1:0] data1_r [NUM_SETS];

    // Way chosen at miss time; the refill writes this way when memory answers.
    logic victim_r;

    logic [SET_BITS-1:0]   idx_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  match0_s;
    logic                  match1_s;
    logic                  lookup_hit_s;
    logic [DATA_WIDTH-1:0] hit_data_s;
    logic                  victim_s;

    logic capture_victim_s;
    logic fill_s;
    logic rd_hit_s;
    logic rd_miss_s;
    logic wr_hit_s;

    // Byte-offset bits are not used: the cache only does word accesses.
    logic unused_byte_offset_s;
    assign unused_byte_offset_s = ^addr[1:0];

    assign idx_s        = addr[SET_BITS+1:2];
    assign tag_s        = addr[ADDR_WIDTH-1:SET_BITS+2];
    assign match0_s     = valid0_r[idx_s] && (tag0_r[idx_s] == tag_s);
    assign match1_s     = valid1_r[idx_s] && (tag1_r[idx_s] == tag_s);
    assign lookup_hit_s = match0_s || match1_s;
    assign hit_data_s   = match0_s ? data0_r[idx_s] : data1_r[idx_s];

    assign mem_addr       = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write_data = write_data;

    // Victim choice: first invalid way (way0 first), otherwise the LRU way.
    always_comb begin
        if (!valid0_r[idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid1_r[idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[idx_s];
        end
    end

    // FSM next state, CPU/memory outputs and the storage update strobes.
    always_comb begin
        state_next_s     = state_r;
        hit              = 1'b0;
        miss             = 1'b0;
        stall            = 1'b0;
        mem_read_en      = 1'b0;
        mem_write_en     = 1'b0;
        read_data        = {DATA_WIDTH{1'b0}};
        capture_victim_s = 1'b0;
        fill_s           = 1'b0;
        rd_hit_s         = 1'b0;
        rd_miss_s        = 1'b0;
        wr_hit_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (write_en) begin
                    // Stores win over loads; the load request is ignored.
                    hit          = lookup_hit_s;
                    miss         = !lookup_hit_s;
                    stall        = 1'b1;
                    wr_hit_s     = lookup_hit_s;
                    state_next_s = ST_WRITE;
                end else if (read_en) begin
                    if (lookup_hit_s) begin
                        hit       = 1'b1;
                        read_data = hit_data_s;
                        rd_hit_s  = 1'b1;
                    end else begin
                        miss             = 1'b1;
                        stall            = 1'b1;
                        rd_miss_s        = 1'b1;
                        capture_victim_s = 1'b1;
                        state_next_s     = ST_REFILL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                mem_read_en = 1'b1;
                if (mem_valid) begin
                    read_data    = mem_read_data;
                    fill_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_WRITE: begin
                mem_write_en = 1'b1;
                if (mem_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Valid bits, LRU bits and the latched victim way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid0_r <= {NUM_SETS{1'b0}};
            valid1_r <= {NUM_SETS{1'b0}};
            lru_r    <= {NUM_SETS{1'b0}};
            victim_r <= 1'b0;
        end else begin
            if (capture_victim_s) begin
                victim_r <= victim_s;
            end
            if (fill_s) begin
                if (victim_r) begin
                    valid1_r[idx_s] <= 1'b1;
                end else begin
                    valid0_r[idx_s] <= 1'b1;
                end
                lru_r[idx_s] <= ~victim_r;
            end else if (rd_hit_s || wr_hit_s) begin
                // The other way of the one just used becomes the replacement candidate.
                lru_r[idx_s] <= match0_s;
            end
        end
    end

    // Tag and data arrays: refill of the victim way, or store-hit data update.
    always_ff @(posedge clk) begin
        if (rst_n && fill_s) begin
            if (victim_r) begin
                tag1_r[idx_s]  <= tag_s;
                data1_r[idx_s] <= mem_read_data;
            end else begin
                tag0_r[idx_s]  <= tag_s;
                data0_r[idx_s] <= mem_read_data;
            end
        end else if (rst_n && wr_hit_s) begin
            if (match0_s) begin
                data0_r[idx_s] <= write_data;
            end else begin
                data1_r[idx_s] <= write_data;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Load hit/miss counters; they wrap naturally on overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (rd_hit_s) begin
                hit_count <= hit_count + 32'd1;
            end
            if (rd_miss_s) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sa_cache_2way.md
Name: sa_cache_2way

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache.
- Successor to the single-cycle direct-mapped cache: the set count is parametrised, it adds LRU replacement, and it adds a clocked miss/refill state machine with a memory-side handshake and a CPU stall signal.
- Sits between the CPU load/store unit and data memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width. Must be 32 because the 2-bit byte offset is fixed.
- SET_BITS, 3, index width. Number of sets = 2**SET_BITS. Tag width = ADDR_WIDTH-SET_BITS-2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- read_en  in  1  CPU load request, held until stall=0.
- write_en  in  1  CPU store request, held until stall=0.
- addr  in  ADDR_WIDTH  byte address. Bits [1:0] are ignored; word access only.
- write_data  in  DATA_WIDTH  store data.
- read_data  out  DATA_WIDTH  load data, valid when read_en=1 and stall=0.
- hit  out  1  lookup hit, combinational, IDLE only.
- miss  out  1  lookup miss, combinational, IDLE only.
- stall  out  1  request not yet complete.
- mem_read_en  out  1  memory line read request.
- mem_write_en  out  1  memory write request.
- mem_addr  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2],2'b00}.
- mem_write_data  out  DATA_WIDTH  equals write_data.
- mem_read_data  in  DATA_WIDTH  memory read data.
- mem_valid  in  1  memory ack for the current read or write (one cycle).

Behaviour:
- Storage: per set, two ways of {valid, tag, data}, plus one LRU bit per set. The LRU bit names the way to replace next.
- Index = addr[SET_BITS+1:2]. Tag = addr[ADDR_WIDTH-1:SET_BITS+2].
- A request completes on a rising edge where stall=0.
- States: IDLE, REFILL, WRITE.
- IDLE, read_en=1, hit:
  - hit=1, read_data=matching way data, stall=0, same cycle.
  - At the edge, LRU := other way. Stay in IDLE.
- IDLE, read_en=1, miss:
  - miss=1, stall=1. Go to REFILL.
  - Victim selection: the first invalid way (way0 first); if both ways are valid, the LRU way.
- REFILL:
  - mem_read_en=1 and stall=1 until mem_valid.
  - In the mem_valid cycle: read_data=mem_read_data and stall=0.
  - At that edge: victim := {1, tag, mem_read_data}, LRU := other way. Go to IDLE.
- IDLE, write_en=1:
  - stall=1, hit/miss reflect the lookup. Go to WRITE.
  - At that edge, on a hit only, update the matching way's data and set LRU := other way.
  - On a miss, no allocation.
- WRITE:
  - mem_write_en=1 and stall=1 until mem_valid.
  - In the mem_valid cycle: stall=0. Go to IDLE.
- read_en and write_en both high: write takes priority; the read is ignored.
- CPU inputs must stay stable while stall=1. Changes during stall are undefined.
- No request in IDLE: hit=miss=stall=0, mem_*_en=0, read_data=0.
- mem_valid in IDLE is ignored.
- hit, miss and stall are 0 outside IDLE except as stated above.
- Reset (rst_n=0 at an edge):
  - All valid bits and LRU bits cleared; state=IDLE.
  - Outputs follow from the IDLE rules.
  - A refill in progress is abandoned: no line is written and mem_read_en is low from the next cycle.
- Address 0 and maximum-index sets behave like any other set.
- A tag compare matches only when the way is valid.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds output ports hit_count (32) and miss_count (32). Both reset to 0 and wrap on overflow.
  - hit_count increments at each edge with IDLE & read_en & hit.
  - miss_count increments at each edge with IDLE & read_en & miss.
  - Writes are not counted.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then read 0x0000_0040 with mem_valid 3 cycles after entering REFILL and mem_read_data=0xDEADBEEF.
  - Expect: miss=1 for one cycle, stall=1 for 3 cycles, read_data=0xDEADBEEF with stall=0 in the fill cycle.
  - Re-read the same address: hit=1, zero stall.
- Fill 0x040 and 0x140 (same set 0, different tags), read 0x040 again, then read 0x240.
  - Expect: 0x140 evicted (LRU); subsequent 0x040 hit; 0x140 miss.
- Write 0x12345678 to a cached 0x040.
  - Expect: stall until mem_valid, mem_write_en=1, mem_addr=0x040; next read of 0x040 hits with 0x12345678.
- Write to uncached 0x080.
  - Expect: memory write issued; next read of 0x080 misses (no allocate).
- Assert rst_n=0 during REFILL, then re-read the same address.
  - Expect: mem_read_en=0 after reset; re-read misses.
- With CACHE_STATS_EN defined: after the scenario-1 sequence, hit_count=1 and miss_count=1.
- Simultaneous read_en=write_en=1 to 0x040.
  - Expect: the write-path behaviour only; no REFILL entered.
